// File: rtl/gpif2_pkg.sv
// Shared constants for the GPIF II bus scheduler: socket addresses,
// FSM state encoding and default timing parameters.
package gpif2_pkg;

    localparam int unsigned BURST_DEF    = 16;
    localparam int unsigned RD_LAT_DEF   = 2;
    localparam int unsigned FLAG_LAT_DEF = 3;
    localparam int unsigned TIMEOUT_DEF  = 64;

    localparam logic [1:0] SOCK_CU2F = 2'd0;
    localparam logic [1:0] SOCK_DU2F = 2'd1;
    localparam logic [1:0] SOCK_DF2U = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD,
        ST_RDLAT,
        ST_WR,
        ST_TURN
    } state_t;

endpackage

// File: rtl/gpif2_rr_arb.sv
// Two-requester round-robin arbiter with a strict-priority override input.
// The pointer flips whenever either round-robin requester wins.
module gpif2_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_hi,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_hi,
    output logic gnt_a,
    output logic gnt_b
);

    logic ptr_b;  // 0: requester a wins a tie, 1: requester b wins

    always_comb begin
        gnt_hi = en & req_hi;
        gnt_a  = en & ~req_hi & req_a & (~req_b | ~ptr_b);
        gnt_b  = en & ~req_hi & req_b & (~req_a | ptr_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_b <= 1'b0;
        end else if (gnt_a | gnt_b) begin
            ptr_b <= ~ptr_b;
        end
    end

endmodule

// File: rtl/gpif2_bus_sched.sv
// FX3 GPIF II slave-FIFO bus scheduler: picks CU2F/DU2F reads or DF2U
// writes, runs one burst, then waits out the flag latency.
module gpif2_bus_sched
    import gpif2_pkg::*;
#(
    parameter int unsigned BURST    = BURST_DEF,
    parameter int unsigned RD_LAT   = RD_LAT_DEF,
    parameter int unsigned FLAG_LAT = FLAG_LAT_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST_N,
    input  logic        ready,
    input  logic        sl_flaga,
    input  logic        sl_flagb,
    input  logic        sl_flagc,
    input  logic [15:0] cu2f_room,
    input  logic [15:0] du2f_room,
    input  logic [15:0] df2u_items,
    output logic [1:0]  sl_ad,
    output logic        sl_rd_n,
    output logic        sl_oe_n,
    output logic        sl_wr_n,
    output logic        sl_pktend_n,
    output logic        sl_dt_oe,
    output logic        cu2f_push,
    output logic        du2f_push,
    output logic        df2u_pop,
    output logic        busy
);

    localparam logic [15:0] BURST_W = 16'(BURST);

    state_t            state, state_nx;
    logic [15:0]       cnt;
    logic [15:0]       wr_len;
    logic [15:0]       timer;
    logic [RD_LAT-1:0] rd_pipe;
    logic              small_pkt, flush, sched_en;
    logic              rq_c, rq_d, rq_w;
    logic              gnt_c, gnt_d, gnt_w;
    logic              is_rd, rd_now;

    assign small_pkt = (df2u_items != '0) && (df2u_items < BURST_W);
    assign flush     = (timer == 16'(TIMEOUT));
    assign sched_en  = (state == ST_IDLE) && ready;
    assign rq_c      = sl_flaga && (cu2f_room >= BURST_W);
    assign rq_d      = sl_flagb && (du2f_room >= BURST_W);
    assign rq_w      = sl_flagc && (df2u_items != '0) && ((df2u_items >= BURST_W) || flush);

    gpif2_rr_arb u_arb (
        .clk    (SYS_CLK),
        .rst_n  (SYS_RST_N),
        .en     (sched_en),
        .req_hi (rq_c),
        .req_a  (rq_d),
        .req_b  (rq_w),
        .gnt_hi (gnt_c),
        .gnt_a  (gnt_d),
        .gnt_b  (gnt_w)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (gnt_c || gnt_d || gnt_w) state_nx = ST_ADDR;
            ST_ADDR:  state_nx = (sl_ad == SOCK_DF2U) ? ST_WR : ST_RD;
            ST_RD:    if (cnt == BURST_W - 16'd1) state_nx = ST_RDLAT;
            ST_RDLAT: if (cnt == 16'(RD_LAT - 1)) state_nx = ST_TURN;
            ST_WR:    if (cnt == wr_len - 16'd1) state_nx = ST_TURN;
            ST_TURN:  if (cnt == 16'(FLAG_LAT - 1)) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sl_ad   <= '0;
            wr_len  <= '0;
            timer   <= '0;
            rd_pipe <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state || state == ST_IDLE) ? '0 : cnt + 16'd1;

            if (gnt_c)
                sl_ad <= SOCK_CU2F;
            else if (gnt_d)
                sl_ad <= SOCK_DU2F;
            else if (gnt_w)
                sl_ad <= SOCK_DF2U;
            else if (state == ST_TURN && state_nx == ST_IDLE)
                sl_ad <= '0;

            if (gnt_w)
                wr_len <= (df2u_items < BURST_W) ? df2u_items : BURST_W;

            // Timer freezes outside IDLE and saturates at TIMEOUT so flush holds.
            if (gnt_w || !small_pkt)
                timer <= '0;
            else if (state == ST_IDLE && !flush)
                timer <= timer + 16'd1;

            rd_pipe[0] <= rd_now;
            for (int unsigned i = 1; i < RD_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    always_comb begin
        is_rd       = (sl_ad != SOCK_DF2U);
        rd_now      = (state == ST_RD);
        sl_rd_n     = !rd_now;
        sl_oe_n     = !((state == ST_ADDR && is_rd) || state == ST_RD || state == ST_RDLAT);
        sl_dt_oe    = (state == ST_ADDR && !is_rd) || state == ST_WR;
        sl_wr_n     = !(state == ST_WR);
        df2u_pop    = (state == ST_WR);
        sl_pktend_n = !(state == ST_WR && wr_len < BURST_W && cnt == wr_len - 16'd1);
        cu2f_push   = rd_pipe[RD_LAT-1] && (sl_ad == SOCK_CU2F);
        du2f_push   = rd_pipe[RD_LAT-1] && (sl_ad == SOCK_DU2F);
        busy        = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_gpif2_bus_sched.sv
// Bench for gpif2_bus_sched: table-driven grant vectors plus hand-written
// burst sequences; every observed burst is scored against an expected queue.
module tb_gpif2_bus_sched;

    typedef struct {
        int sock, rd, push_c, push_d, pop, wr, pkt, pkt_at, delay_err, tail, ad_err;
    } obs_t;

    typedef struct {
        int sock, rd, push, pop, wr, pkt_at;
    } exp_t;

    typedef struct {
        bit rdy, fa, fb, fc;
        int croom, droom, items, sock, n;
    } vec_t;

    logic        clk, rst_n, ready, flaga, flagb, flagc;
    logic [15:0] cu2f_room, du2f_room, df2u_items;
    logic [1:0]  sl_ad;
    logic        sl_rd_n, sl_oe_n, sl_wr_n, sl_pktend_n, sl_dt_oe;
    logic        cu2f_push, du2f_push, df2u_pop, busy;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    obs_t obs[64];
    int   obs_wr = 0;
    int   obs_rd = 0;
    int   ovl = 0;
    int   ad_idle_err = 0;

    gpif2_bus_sched #(
        .BURST    (16),
        .RD_LAT   (2),
        .FLAG_LAT (3),
        .TIMEOUT  (64)
    ) dut (
        .SYS_CLK     (clk),
        .SYS_RST_N   (rst_n),
        .ready       (ready),
        .sl_flaga    (flaga),
        .sl_flagb    (flagb),
        .sl_flagc    (flagc),
        .cu2f_room   (cu2f_room),
        .du2f_room   (du2f_room),
        .df2u_items  (df2u_items),
        .sl_ad       (sl_ad),
        .sl_rd_n     (sl_rd_n),
        .sl_oe_n     (sl_oe_n),
        .sl_wr_n     (sl_wr_n),
        .sl_pktend_n (sl_pktend_n),
        .sl_dt_oe    (sl_dt_oe),
        .cu2f_push   (cu2f_push),
        .du2f_push   (du2f_push),
        .df2u_pop    (df2u_pop),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    bus_dir_exclusive: assert property (@(negedge clk) disable iff (!rst_n) !(sl_dt_oe && !sl_oe_n));

    // Burst monitor: collects one record per busy period, abandons on reset.
    int   cyc = 0;
    int   rd_time[32];
    bit   in_b = 0;
    obs_t cur;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_b = 0;
        end else begin
            if (sl_dt_oe && !sl_oe_n) ovl++;
            if (!busy && sl_ad != 2'd0) ad_idle_err++;
            if (busy) begin
                if (!in_b) begin
                    in_b = 1;
                    cur = '{default: 0};
                    cur.sock = int'(sl_ad);
                end
                if (int'(sl_ad) != cur.sock) cur.ad_err++;
                if (!sl_rd_n) begin
                    if (cur.rd < 32) rd_time[cur.rd] = cyc;
                    cur.rd++;
                end
                if (cu2f_push || du2f_push) begin
                    int idx;
                    idx = cur.push_c + cur.push_d;
                    if (idx >= cur.rd || idx >= 32 || cyc != rd_time[idx] + 2) cur.delay_err++;
                end
                if (cu2f_push) cur.push_c++;
                if (du2f_push) cur.push_d++;
                if (df2u_pop != !sl_wr_n) cur.delay_err++;
                if (df2u_pop) cur.pop++;
                if (!sl_wr_n) cur.wr++;
                if (!sl_pktend_n) begin
                    if (sl_wr_n) cur.delay_err++;
                    cur.pkt++;
                    cur.pkt_at = cur.wr;
                end
                if (!sl_rd_n || cu2f_push || du2f_push || df2u_pop || !sl_wr_n)
                    cur.tail = 0;
                else
                    cur.tail++;
            end else if (in_b) begin
                obs[obs_wr % 64] = cur;
                obs_wr++;
                in_b = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int sock, input int n);
        exp_t e;
        if (sock < 2) e = '{sock: sock, rd: 16, push: 16, pop: 0, wr: 0, pkt_at: 0};
        else          e = '{sock: sock, rd: 0, push: 0, pop: n, wr: n, pkt_at: (n < 16) ? n : 0};
        return e;
    endfunction

    function automatic int outs();
        return int'({sl_ad, sl_rd_n, sl_oe_n, sl_wr_n, sl_pktend_n, sl_dt_oe,
                     cu2f_push, du2f_push, df2u_pop, busy});
    endfunction

    task automatic set_idle();
        ready = 1'b1; flaga = 1'b0; flagb = 1'b0; flagc = 1'b0;
        cu2f_room = 16'd100; du2f_room = 16'd100; df2u_items = 16'd0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin @(negedge clk); t++; end
        if (busy) check("idle_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_busy();
        int t = 0;
        while (!busy && t < 200) begin @(negedge clk); t++; end
        if (!busy) check("busy_timeout", 0, 1);
    endtask

    task automatic check_burst();
        int   t = 0;
        exp_t e;
        obs_t o;
        while (obs_rd == obs_wr && t < 3000) begin @(negedge clk); t++; end
        if (obs_rd == obs_wr) begin
            check("burst_timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        o = obs[obs_rd % 64];
        obs_rd++;
        if (exp_q.size() == 0) begin
            check("unexpected_burst", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("sock", o.sock, e.sock);
        check("rd_lows", o.rd, e.rd);
        check("cu2f_push", o.push_c, (e.sock == 0) ? e.push : 0);
        check("du2f_push", o.push_d, (e.sock == 1) ? e.push : 0);
        check("pops", o.pop, e.pop);
        check("wr_lows", o.wr, e.wr);
        check("pktend_count", o.pkt, (e.pkt_at != 0) ? 1 : 0);
        check("pktend_pos", o.pkt_at, e.pkt_at);
        check("strobe_timing", o.delay_err, 0);
        check("turn_cycles", o.tail, 3);
        check("ad_stable", o.ad_err, 0);
    endtask

    vec_t vecs[12];

    initial begin
        int got, n, idle;

        //          rdy   fa    fb    fc    croom droom items sock n
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16,  100,  0,   0,  0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 15,  100,  0,  -1,  0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 100, 100,  0,   0,  0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 100, 16,   0,   1,  0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 100, 100,  16,  2, 16};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 100, 100,  20,  1,  0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 100, 100,  40,  2, 16};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 100, 100,  20,  1,  0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 100, 100,  16,  2, 16};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 100, 100,  40, -1,  0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 100, 100,  0,  -1,  0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 100, 15,   0,  -1,  0};

        set_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), int'(11'b00111100000));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", outs(), int'(11'b00111100000));

        foreach (vecs[k]) begin
            wait_idle();
            ready = vecs[k].rdy; flaga = vecs[k].fa; flagb = vecs[k].fb; flagc = vecs[k].fc;
            cu2f_room = 16'(vecs[k].croom); du2f_room = 16'(vecs[k].droom);
            df2u_items = 16'(vecs[k].items);
            got = 0;
            for (int c = 0; c < 4 && got == 0; c++) begin
                @(negedge clk);
                if (busy) got = 1;
            end
            if (vecs[k].sock < 0) begin
                check("no_grant", got, 0);
                set_idle();
            end else begin
                check("grant", got, 1);
                exp_q.push_back(mk_exp(vecs[k].sock, vecs[k].n));
                @(posedge clk); #1 set_idle();
                check_burst();
            end
        end

        // DU2F and DF2U both requesting continuously alternate.
        wait_idle();
        flagb = 1'b1; flagc = 1'b1; df2u_items = 16'd40;
        exp_q.push_back(mk_exp(1, 0));
        exp_q.push_back(mk_exp(2, 16));
        exp_q.push_back(mk_exp(1, 0));
        check_burst();
        check_burst();
        wait_busy();
        @(posedge clk); #1 set_idle();
        check_burst();

        // Flag and room collapse mid-read must not shorten the burst.
        wait_idle();
        flagb = 1'b1;
        exp_q.push_back(mk_exp(1, 0));
        wait_busy();
        n = 0;
        for (int t = 0; t < 100 && n < 4; t++) begin
            @(negedge clk);
            if (!sl_rd_n) n++;
        end
        #1 flagb = 1'b0; du2f_room = 16'd0;
        check_burst();
        set_idle();

        // Short DF2U packet flushed after the idle timeout.
        wait_idle();
        flagc = 1'b1; df2u_items = 16'd5;
        exp_q.push_back(mk_exp(2, 5));
        idle = 0;
        while (!busy && idle < 200) begin
            @(negedge clk);
            if (!busy) idle++;
        end
        check("flush_wait_in_range", (idle >= 64 && idle <= 66) ? 1 : 0, 1);
        if (idle < 64 || idle > 66) $display("FAIL flush_wait: got %0d idle cycles expected 64..66", idle);
        @(posedge clk); #1 set_idle();
        check_burst();

        // Reset in the middle of a write burst abandons it.
        wait_idle();
        flagc = 1'b1; df2u_items = 16'd40;
        wait_busy();
        n = 0;
        for (int t = 0; t < 100 && n < 8; t++) begin
            @(negedge clk);
            if (!sl_wr_n) n++;
        end
        check("reached_write_word8", n, 8);
        #1 rst_n = 1'b0;
        #1 check("reset_mid_write", outs(), int'(11'b00111100000));
        set_idle();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (df2u_pop || !sl_wr_n) n++;
        end
        check("no_pops_after_reset", n, 0);
        check("idle_after_reset", int'(busy), 0);

        check("oe_dt_overlap", ovl, 0);
        check("idle_addr_nonzero", ad_idle_err, 0);
        check("leftover_bursts", obs_wr - obs_rd, 0);
        check("leftover_expected", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpif2_bus_sched.md
GPIF2_BUS_SCHED -- requirements
Module: gpif2_bus_sched

Interface
REQ-001 Parameter BURST, default 16: words per full transfer; FX3 flag high means at least BURST words (read) or BURST free slots (write).
REQ-002 Parameter RD_LAT, default 2: cycles from sl_rd_n low to valid read data.
REQ-003 Parameter FLAG_LAT, default 3: cycles after a burst before flags are valid again.
REQ-004 Parameter TIMEOUT, default 64: idle cycles before a short DF2U packet is flushed.
REQ-005 SYS_CLK  in  1  single clock for all logic.
REQ-006 SYS_RST_N  in  1  asynchronous, active-low reset.
REQ-007 ready  in  1  scheduling enable; low lets the current burst finish, then holds IDLE.
REQ-008 sl_flaga / sl_flagb / sl_flagc  in  1 each  synchronized flags: CU2F readable, DU2F readable, DF2U writable.
REQ-009 cu2f_room / du2f_room  in  16 each  free words in the local CU2F and DU2F FIFOs.
REQ-010 df2u_items  in  16  words held in the local first-word-fall-through DF2U FIFO.
REQ-011 sl_ad  out  2  socket address: 0=CU2F, 1=DU2F, 2=DF2U.
REQ-012 sl_rd_n, sl_oe_n, sl_wr_n, sl_pktend_n  out  1 each  FX3 strobes, active-low.
REQ-013 sl_dt_oe  out  1  SL_DT tristate enable: FPGA drives the bus when high.
REQ-014 cu2f_push, du2f_push, df2u_pop  out  1 each  local FIFO strobes, one word each.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 Requests are evaluated only in IDLE and only while ready=1.
- rq_c = sl_flaga & cu2f_room>=BURST
- rq_d = sl_flagb & du2f_room>=BURST
- rq_w = sl_flagc & (df2u_items>=BURST | flush)
REQ-017 rq_c has strict priority; rq_d and rq_w share round-robin; the pointer toggles only when one of them is granted.
REQ-018 FSM states: IDLE, ADDR, RD, RDLAT, WR, TURN.
- IDLE->ADDR on grant.
- ADDR (1 cycle) -> RD or WR.
- RD -> RDLAT after BURST cycles.
- RDLAT -> TURN after RD_LAT cycles.
- WR -> TURN after n cycles.
- TURN -> IDLE after FLAG_LAT cycles.
REQ-019 ADDR drives sl_ad to the granted socket; sl_ad holds that value until TURN exits, and is 0 in IDLE.
REQ-020 Read bursts:
- sl_rd_n is low for exactly BURST consecutive RD cycles.
- sl_oe_n is low from ADDR through the end of RDLAT.
- The selected push strobe is high in exactly BURST cycles, each RD_LAT cycles after the matching sl_rd_n low cycle.
REQ-021 Write bursts:
- n = min(df2u_items, BURST), sampled at grant.
- sl_dt_oe is high from ADDR through the end of WR.
- sl_wr_n and df2u_pop are low/high together for n consecutive cycles.
REQ-022 If n<BURST, sl_pktend_n is low together with the last sl_wr_n low cycle; for a full burst it stays high.
REQ-023 Flush timer:
- Counts while 0<df2u_items<BURST and state is IDLE.
- Clears on any DF2U grant or when df2u_items is 0 or at least BURST.
- flush asserts when the count reaches TIMEOUT and stays asserted until the timer clears.
REQ-024 sl_dt_oe and sl_oe_n low are never active in the same cycle; ADDR always gives at least one bus-turnaround cycle.
REQ-025 Flag or room changes during a burst have no effect; the burst always completes its committed length.
REQ-026 ready falling mid-burst has no effect on that burst; no new grant is made until ready returns high.

Reset
REQ-027 On SYS_RST_N low, asynchronously:
- State goes to IDLE and sl_ad to 0.
- All _n strobes go to 1.
- sl_dt_oe, pushes, pop and busy go to 0.
- The timer and round-robin pointer (which points to DU2F) are cleared.
- A burst interrupted by reset is abandoned, not resumed.

Structure
REQ-028 Socket address constants, FSM state encoding and default parameter values belong in the shared gpif2 package.
REQ-029 One sub-module, gpif2_rr_arb (two-requester round-robin with priority override), is natural; all other logic stays in the top.

Verification
REQ-030 rq_c and rq_d asserted together -> CU2F served first, sl_ad=0, 16 sl_rd_n lows, 16 cu2f_push highs each delayed by 2 cycles.
REQ-031 rq_d and rq_w asserted continuously -> grants alternate DU2F, DF2U, DU2F; each burst is followed by 3 TURN cycles.
REQ-032 df2u_items=5, sl_flagc=1, no other request -> after 64 idle cycles: 5 pops, 5 sl_wr_n lows, sl_pktend_n low only on the 5th.
REQ-033 sl_flagb drops at read word 4 -> the burst still completes 16 reads and 16 du2f_push strobes.
REQ-034 SYS_RST_N pulsed low at write word 8 -> all strobes inactive the same cycle, state IDLE, no pops after reset release.
REQ-035 Over all runs -> sl_dt_oe=1 and sl_oe_n=0 never occur together (assertion).
